// File: rtl/spi_apb_pkg.sv
// Shared constants for the APB-to-SPI register interface: register addresses,
// CR1/SR bit positions and spi_mode encodings.
package spi_apb_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_BR  = 3'd1;
  localparam logic [2:0] ADDR_DR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_SSR = 3'd4;
  localparam logic [2:0] ADDR_CR2 = 3'd5;

  localparam int CR1_SPIE  = 7;
  localparam int CR1_SPE   = 6;
  localparam int CR1_SPTIE = 5;
  localparam int CR1_MSTR  = 4;
  localparam int CR1_CPOL  = 3;
  localparam int CR1_CPHA  = 2;
  localparam int CR1_SSOE  = 1;
  localparam int CR1_LSBFE = 0;

  localparam int SR_SPIF    = 7;
  localparam int SR_RXFULL  = 6;
  localparam int SR_SPTEF   = 5;
  localparam int SR_TXEMPTY = 4;
  localparam int SR_RXOVF   = 2;
  localparam int SR_TIP     = 1;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;
  localparam logic [1:0] MODE_STOP = 2'b10;

  // Addresses above CR2 are unmapped and always answer with an error.
  function automatic logic is_reserved(input logic [2:0] addr);
    return addr > ADDR_CR2;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is only honoured when a
// pop happens in the same cycle, so the occupancy never exceeds DEPTH.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_spi_regif_fifo.sv
// APB register front-end for the SPI master: config registers, TX/RX FIFOs,
// slave-select decode, transmit handshake towards the shift core and interrupt.
module apb_spi_regif_fifo
  import spi_apb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [2:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              tip,
  input  logic              receive_data,
  input  logic [DATA_W-1:0] miso_data,
  output logic              send_data,
  output logic [DATA_W-1:0] mosi_data,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic [NUM_SS-1:0] ss_n,
  output logic              spi_interrupt_request
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] SS_LIMIT = 4'(NUM_SS);

  logic [7:0]        r_cr1;
  logic [2:0]        r_sppr;
  logic [2:0]        r_spr;
  logic [2:0]        r_ssr;
  logic              r_spiswai;
  logic              r_rx_ovf;
  logic              r_busy;
  logic              r_tip_q;
  logic              r_send_data;
  logic [DATA_W-1:0] r_mosi_data;

  logic              w_access, w_wr, w_rd, w_reserved, w_ssr_bad, w_flush;
  logic              w_wr_dr, w_rd_dr, w_issue, w_ss_active;
  logic              w_tx_push, w_tx_full, w_tx_empty;
  logic              w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
  logic [DATA_W-1:0] w_tx_dout, w_rx_dout;
  logic [CW-1:0]     w_tx_count, w_rx_count;
  logic              w_spif, w_rxfull_st, w_sptef, w_txempty_st;
  logic [7:0]        w_sr;

  assign w_access   = PSEL & PENABLE;
  assign w_wr       = w_access & PWRITE;
  assign w_rd       = w_access & ~PWRITE;
  assign w_reserved = is_reserved(PADDR);
  assign w_ssr_bad  = ({1'b0, PWDATA[2:0]} >= SS_LIMIT);
  assign w_wr_dr    = w_wr & (PADDR == ADDR_DR);
  assign w_rd_dr    = w_rd & (PADDR == ADDR_DR);
  assign w_flush    = w_wr & (PADDR == ADDR_CR1) & ~PWDATA[CR1_SPE];

  assign w_tx_push  = w_wr_dr & ~w_tx_full;
  assign w_rx_pop   = w_rd_dr & ~w_rx_empty;
  assign w_rx_drop  = receive_data & w_rx_full & ~w_rx_pop;

  assign w_spif       = (w_rx_count != '0);
  assign w_rxfull_st  = (w_rx_count == CW'(FIFO_DEPTH));
  assign w_sptef      = (w_tx_count != CW'(FIFO_DEPTH));
  assign w_txempty_st = (w_tx_count == '0);
  assign w_sr = {w_spif, w_rxfull_st, w_sptef, w_txempty_st, 1'b0, r_rx_ovf, tip, 1'b0};

  assign PREADY    = 1'b1;
  assign send_data = r_send_data;
  assign mosi_data = r_mosi_data;
  assign mstr      = r_cr1[CR1_MSTR];
  assign cpol      = r_cr1[CR1_CPOL];
  assign cpha      = r_cr1[CR1_CPHA];
  assign lsbfe     = r_cr1[CR1_LSBFE];
  assign spiswai   = r_spiswai;
  assign sppr      = r_sppr;
  assign spr       = r_spr;

  assign spi_mode = !r_cr1[CR1_SPE] ? MODE_STOP : (r_spiswai ? MODE_WAIT : MODE_RUN);

  // A CR1 write that clears spe also blocks an issue at the same edge.
  assign w_issue = r_cr1[CR1_SPE] & r_cr1[CR1_MSTR] & ~r_busy & ~tip & ~w_tx_empty &
                   (spi_mode == MODE_RUN) & ~w_flush;

  assign w_ss_active = r_cr1[CR1_SSOE] & r_cr1[CR1_MSTR] & (r_busy | tip);

  assign spi_interrupt_request = (r_cr1[CR1_SPIE] & (w_spif | r_rx_ovf)) |
                                 (r_cr1[CR1_SPTIE] & w_sptef);

  assign PSLVERR = w_access & (w_reserved |
                               (w_wr_dr & w_tx_full) |
                               (w_rd_dr & w_rx_empty) |
                               (PWRITE & (PADDR == ADDR_SSR) & w_ssr_bad));

  always_comb begin
    for (int i = 0; i < NUM_SS; i++) begin
      ss_n[i] = ~(w_ss_active & (r_ssr == 3'(i)));
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_access) begin
      case (PADDR)
        ADDR_CR1: PRDATA[7:0] = r_cr1;
        ADDR_BR:  PRDATA[7:0] = {1'b0, r_sppr, 1'b0, r_spr};
        ADDR_DR:  PRDATA      = w_rx_empty ? '0 : w_rx_dout;
        ADDR_SR:  PRDATA[7:0] = w_sr;
        ADDR_SSR: PRDATA[7:0] = {5'd0, r_ssr};
        ADDR_CR2: PRDATA[7:0] = {7'd0, r_spiswai};
        default:  PRDATA      = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cr1     <= '0;
      r_sppr    <= '0;
      r_spr     <= '0;
      r_ssr     <= '0;
      r_spiswai <= 1'b0;
    end else if (w_wr) begin
      case (PADDR)
        ADDR_CR1: r_cr1 <= PWDATA[7:0];
        ADDR_BR: begin
          r_sppr <= PWDATA[6:4];
          r_spr  <= PWDATA[2:0];
        end
        ADDR_SSR: if (!w_ssr_bad) r_ssr <= PWDATA[2:0];
        ADDR_CR2: r_spiswai <= PWDATA[0];
        default: ;
      endcase
    end
  end

  // A new overflow wins over a same-cycle write-1-to-clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rx_ovf <= 1'b0;
    end else if (w_flush) begin
      r_rx_ovf <= 1'b0;
    end else if (w_rx_drop) begin
      r_rx_ovf <= 1'b1;
    end else if (w_wr && PADDR == ADDR_SR && PWDATA[SR_RXOVF]) begin
      r_rx_ovf <= 1'b0;
    end
  end

  // busy covers the gap between send_data and the core raising tip.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_busy      <= 1'b0;
      r_tip_q     <= 1'b0;
      r_send_data <= 1'b0;
      r_mosi_data <= '0;
    end else begin
      r_tip_q     <= tip;
      r_send_data <= w_issue;
      if (w_issue) r_mosi_data <= w_tx_dout;
      if (w_flush)                r_busy <= 1'b0;
      else if (w_issue)           r_busy <= 1'b1;
      else if (r_tip_q && !tip)   r_busy <= 1'b0;
    end
  end

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .flush (w_flush),
    .push  (w_tx_push),
    .pop   (w_issue),
    .din   (PWDATA),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (w_tx_count)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .flush (w_flush),
    .push  (receive_data),
    .pop   (w_rx_pop),
    .din   (miso_data),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (w_rx_count)
  );

endmodule

// File: tb/tb_apb_spi_regif_fifo.sv
// Self-checking bench for apb_spi_regif_fifo: APB accesses, a simple SPI core
// model driving tip, and TX/RX scoreboards of expected frames.
module tb_apb_spi_regif_fifo;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [2:0] PADDR;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic       tip, receive_data, send_data;
  logic [7:0] miso_data, mosi_data;
  logic       mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0] sppr, spr;
  logic [1:0] spi_mode;
  logic [3:0] ss_n;
  logic       spi_interrupt_request;

  logic       tipHold = 1'b0;
  logic       coreTip = 1'b0;
  int         coreCnt = 0;
  int         sendCount = 0;
  int         compareCount = 0;
  int         mismatchCount = 0;
  logic       rxOvfModel = 1'b0;
  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];

  assign tip = tipHold | coreTip;

  always #5 PCLK = ~PCLK;

  apb_spi_regif_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .NUM_SS(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tip(tip), .receive_data(receive_data), .miso_data(miso_data), .send_data(send_data),
    .mosi_data(mosi_data), .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode), .ss_n(ss_n),
    .spi_interrupt_request(spi_interrupt_request)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Core model: every send_data pops the TX scoreboard and raises tip for 8 cycles.
  always @(negedge PCLK) begin
    if (coreCnt > 0) begin
      coreCnt--;
      if (coreCnt == 0) coreTip = 1'b0;
    end
    if (PRESETn && send_data === 1'b1) begin
      sendCount++;
      if (txExpQ.size() == 0) checkOutput("spuriousSend", 32'd1, 32'd0);
      else checkOutput("mosi", mosi_data, txExpQ.pop_front());
      coreTip = 1'b1;
      coreCnt = 8;
    end
  end

  function automatic logic [7:0] expSr(int rxN, int txN, logic ovf, logic tp);
    return {rxN != 0, rxN == 4, txN != 4, txN == 0, 1'b0, ovf, tp, 1'b0};
  endfunction

  task automatic applyStimulus(input logic wr, input logic [2:0] addr, input logic [7:0] wdata,
                               input logic rxPulse, input logic [7:0] rxData,
                               output logic [7:0] rdata, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (rxPulse) begin receive_data = 1'b1; miso_data = rxData; end
    @(negedge PCLK);
    rdata = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; receive_data = 1'b0;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [7:0] data, input logic expErr, input string tag);
    logic [7:0] rd;
    logic err;
    applyStimulus(1'b1, addr, data, 1'b0, 8'h00, rd, err);
    checkOutput({tag, "_err"}, err, expErr);
  endtask

  task automatic readReg(input logic [2:0] addr, input logic [7:0] expData, input logic expErr, input string tag);
    logic [7:0] rd;
    logic err;
    applyStimulus(1'b0, addr, 8'h00, 1'b0, 8'h00, rd, err);
    checkOutput({tag, "_data"}, rd, expData);
    checkOutput({tag, "_err"}, err, expErr);
  endtask

  task automatic pulseRx(input logic [7:0] data);
    @(posedge PCLK); #1;
    receive_data = 1'b1; miso_data = data;
    if (rxExpQ.size() < 4) rxExpQ.push_back(data);
    else rxOvfModel = 1'b1;
    @(posedge PCLK); #1;
    receive_data = 1'b0;
  endtask

  task automatic waitTxDrain(input string tag);
    int n = 0;
    while ((txExpQ.size() != 0 || coreTip) && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    checkOutput(tag, txExpQ.size(), 32'd0);
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic err;
    int sendBefore;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 3'd0; PWDATA = 8'h00; receive_data = 1'b0; miso_data = 8'h00;
    repeat (3) @(negedge PCLK);
    checkOutput("rst_ssn", ss_n, 4'hF);
    checkOutput("rst_mode", spi_mode, 2'b10);
    checkOutput("rst_pready", PREADY, 1'b1);
    checkOutput("rst_pslverr", PSLVERR, 1'b0);
    checkOutput("rst_prdata", PRDATA, 8'h00);
    checkOutput("rst_send", {send_data, mosi_data}, 9'h000);
    checkOutput("rst_irq", spi_interrupt_request, 1'b0);
    PRESETn = 1'b1;

    $display("[TB] register reset values and config decode");
    readReg(3'd0, 8'h00, 1'b0, "cr1Rst");
    readReg(3'd1, 8'h00, 1'b0, "brRst");
    readReg(3'd3, 8'h30, 1'b0, "srRst");
    @(negedge PCLK);
    checkOutput("idlePrdata", PRDATA, 8'h00);
    writeReg(3'd1, 8'hFF, 1'b0, "brWr");
    readReg(3'd1, 8'h77, 1'b0, "brRd");
    checkOutput("brOut", {sppr, spr}, 6'o77);
    writeReg(3'd0, 8'h52, 1'b0, "cr1Wr");
    checkOutput("cfgBits", {mstr, cpol, cpha, lsbfe}, 4'b1000);
    checkOutput("modeRun", spi_mode, 2'b00);
    writeReg(3'd5, 8'h01, 1'b0, "cr2Wr");
    checkOutput("modeWait", {spiswai, spi_mode}, 3'b101);
    writeReg(3'd5, 8'h00, 1'b0, "cr2Clr");
    writeReg(3'd4, 8'h04, 1'b1, "ssrBad");
    writeReg(3'd4, 8'h03, 1'b0, "ssrMax");
    readReg(3'd4, 8'h03, 1'b0, "ssrRd3");
    writeReg(3'd4, 8'h02, 1'b0, "ssr2");
    readReg(3'd6, 8'h00, 1'b1, "rsv6");
    writeReg(3'd7, 8'hFF, 1'b1, "rsv7");

    $display("[TB] single frame latency and slave select");
    txExpQ.push_back(8'hA5);
    writeReg(3'd2, 8'hA5, 1'b0, "drA5");
    @(negedge PCLK);
    checkOutput("sendEarly", send_data, 1'b0);
    @(negedge PCLK);
    checkOutput("sendLatency", send_data, 1'b1);
    checkOutput("ssActive", ss_n, 4'b1011);
    waitTxDrain("drainA5");
    checkOutput("ssIdle", ss_n, 4'hF);

    $display("[TB] TX FIFO full with tip held");
    tipHold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      txExpQ.push_back(8'(i));
      writeReg(3'd2, 8'(i), 1'b0, "txFill");
    end
    writeReg(3'd2, 8'h05, 1'b1, "txOverfill");
    readReg(3'd3, expSr(0, 4, 1'b0, 1'b1), 1'b0, "srTxFull");
    tipHold = 1'b0;
    waitTxDrain("drainFour");

    $display("[TB] RX overflow, interrupt and sticky flag");
    writeReg(3'd0, 8'hF2, 1'b0, "cr1Sptie");
    checkOutput("irqSptef", spi_interrupt_request, 1'b1);
    writeReg(3'd0, 8'hD2, 1'b0, "cr1Spie");
    checkOutput("irqQuiet", spi_interrupt_request, 1'b0);
    for (int i = 0; i < 5; i++) pulseRx(8'h11 + 8'(i));
    @(negedge PCLK);
    checkOutput("irqRx", spi_interrupt_request, 1'b1);
    readReg(3'd3, expSr(rxExpQ.size(), 0, rxOvfModel, 1'b0), 1'b0, "srRxOvf");
    while (rxExpQ.size() != 0) readReg(3'd2, rxExpQ.pop_front(), 1'b0, "rxRead");
    readReg(3'd2, 8'h00, 1'b1, "rxEmptyRead");
    readReg(3'd3, expSr(0, 0, rxOvfModel, 1'b0), 1'b0, "srOvfSticky");
    writeReg(3'd3, 8'h04, 1'b0, "srClr");
    rxOvfModel = 1'b0;
    readReg(3'd3, expSr(0, 0, rxOvfModel, 1'b0), 1'b0, "srAfterClr");
    checkOutput("irqCleared", spi_interrupt_request, 1'b0);

    $display("[TB] simultaneous push and pop on full RX FIFO");
    for (int i = 0; i < 4; i++) pulseRx(8'h21 + 8'(i));
    applyStimulus(1'b0, 3'd2, 8'h00, 1'b1, 8'h25, rd, err);
    checkOutput("simPopData", rd, rxExpQ.pop_front());
    checkOutput("simErr", err, 1'b0);
    rxExpQ.push_back(8'h25);
    readReg(3'd3, expSr(rxExpQ.size(), 0, rxOvfModel, 1'b0), 1'b0, "srSimFull");
    while (rxExpQ.size() != 0) readReg(3'd2, rxExpQ.pop_front(), 1'b0, "rxSimRead");

    $display("[TB] spe clear flushes both FIFOs");
    tipHold = 1'b1;
    txExpQ.push_back(8'h31);
    writeReg(3'd2, 8'h31, 1'b0, "flTx1");
    txExpQ.push_back(8'h32);
    writeReg(3'd2, 8'h32, 1'b0, "flTx2");
    pulseRx(8'h41);
    pulseRx(8'h42);
    sendBefore = sendCount;
    writeReg(3'd0, 8'h12, 1'b0, "cr1SpeOff");
    txExpQ.delete();
    rxExpQ.delete();
    rxOvfModel = 1'b0;
    readReg(3'd3, expSr(0, 0, 1'b0, 1'b1), 1'b0, "srFlushed");
    tipHold = 1'b0;
    repeat (20) @(negedge PCLK);
    checkOutput("noSendAfterFlush", sendCount, sendBefore);
    checkOutput("modeStop", spi_mode, 2'b10);

    $display("[TB] asynchronous reset during a transfer");
    writeReg(3'd4, 8'h00, 1'b0, "ssr0");
    writeReg(3'd0, 8'h52, 1'b0, "cr1Again");
    txExpQ.push_back(8'h77);
    writeReg(3'd2, 8'h77, 1'b0, "dr77");
    repeat (3) @(negedge PCLK);
    checkOutput("ssMidXfer", ss_n, 4'b1110);
    @(posedge PCLK); #3;
    PRESETn = 1'b0;
    #1;
    checkOutput("ssAsyncRst", ss_n, 4'hF);
    checkOutput("modeAsyncRst", spi_mode, 2'b10);
    @(negedge PCLK);
    PRESETn = 1'b1;
    waitTxDrain("drainAfterRst");
    readReg(3'd0, 8'h00, 1'b0, "cr1AfterRst");
    readReg(3'd3, 8'h30, 1'b0, "srAfterRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
